// File: rtl/period_meter_pkg.sv
// period_meter_pkg
// Shared definitions for the reference-input period meter.
//   state_t        : measurement FSM encoding (IDLE, COUNT, TRACK)
//   DEFAULT_WIDTH  : count width shared with the frequency divider's period input
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH       = 12;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/period_meter_edge_sync.sv
// edge_sync
// Brings an asynchronous square wave into the clk domain and flags every
// transition (rising or falling) as a one-cycle pulse.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   sig_in    in   asynchronous input
//   sig_edge  out  high for one cycle after each synchronized transition
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_edge
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[0] <= 1'b0;
                    else     sync_reg[0] <= sig_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // History flop: one cycle behind the last synchronizer stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_reg <= 1'b0;
        else     hist_reg <= sync_reg[SYNC_STAGES-1];
    end

    assign sig_edge = sync_reg[SYNC_STAGES-1] ^ hist_reg;

endmodule

// File: rtl/period_meter.sv
// period_meter
// Measures the edge-to-edge distance (half-period) of an asynchronous square
// wave in clk_in cycles, and reports validity, timeout and lock status.
// Ports:
//   clk_in        in   system clock, posedge
//   reset         in   asynchronous active-high reset
//   sig_in        in   asynchronous reference input
//   period_out    out  last measured half-period (WIDTH bits)
//   period_valid  out  one-cycle strobe when period_out updates
//   locked        out  high while consecutive measurements agree within TOL
//   timeout       out  one-cycle strobe when no edge arrives for 2^WIDTH-1 cycles
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int TOL         = 1,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0]   CNT_MAX    = '1;
    localparam logic [WIDTH-1:0]   TOL_W      = WIDTH'(TOL);
    localparam int                 MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);

    logic               sig_edge;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   prev_reg, prev_next;
    logic [WIDTH-1:0]   period_reg, period_next;
    logic [MATCH_W-1:0] match_reg, match_next;
    logic               valid_reg, valid_next;
    logic               locked_reg, locked_next;
    logic               timeout_reg, timeout_next;

    logic [WIDTH-1:0]   diff;
    logic [MATCH_W-1:0] match_inc;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk_in),
        .rst      (reset),
        .sig_in   (sig_in),
        .sig_edge (sig_edge)
    );

    // Magnitude of the change between consecutive intervals, never wrapping.
    assign diff      = (cnt_reg >= prev_reg) ? (cnt_reg - prev_reg) : (prev_reg - cnt_reg);
    assign match_inc = (match_reg == MATCH_FULL) ? MATCH_FULL : (match_reg + MATCH_W'(1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            prev_reg    <= '0;
            period_reg  <= '0;
            match_reg   <= '0;
            valid_reg   <= 1'b0;
            locked_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            prev_reg    <= prev_next;
            period_reg  <= period_next;
            match_reg   <= match_next;
            valid_reg   <= valid_next;
            locked_reg  <= locked_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        prev_next    = prev_reg;
        period_next  = period_reg;
        match_next   = match_reg;
        valid_next   = 1'b0;
        locked_next  = locked_reg;
        timeout_next = 1'b0;

        // The counter restarts at 1 on every edge so two edges k cycles apart
        // read back k; it saturates instead of wrapping.
        if (sig_edge)               cnt_next = WIDTH'(1);
        else if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + WIDTH'(1);
        else                        cnt_next = cnt_reg;

        unique case (state_reg)
            IDLE: begin
                if (sig_edge) state_next = COUNT;
            end

            COUNT: begin
                // An edge arriving exactly at saturation is still a valid measurement.
                if (sig_edge) begin
                    period_next = cnt_reg;
                    valid_next  = 1'b1;
                    prev_next   = cnt_reg;
                    match_next  = '0;
                    locked_next = 1'b0;
                    state_next  = TRACK;
                end else if (cnt_reg == CNT_MAX) begin
                    timeout_next = 1'b1;
                    locked_next  = 1'b0;
                    match_next   = '0;
                    state_next   = IDLE;
                end
            end

            TRACK: begin
                if (sig_edge) begin
                    period_next = cnt_reg;
                    valid_next  = 1'b1;
                    prev_next   = cnt_reg;
                    if (diff <= TOL_W) begin
                        match_next  = match_inc;
                        locked_next = (match_inc == MATCH_FULL);
                    end else begin
                        match_next  = '0;
                        locked_next = 1'b0;
                    end
                end else if (cnt_reg == CNT_MAX) begin
                    timeout_next = 1'b1;
                    locked_next  = 1'b0;
                    match_next   = '0;
                    state_next   = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign period_out   = period_reg;
    assign period_valid = valid_reg;
    assign locked       = locked_reg;
    assign timeout      = timeout_reg;

endmodule
